// File: rtl/ysyx_23060203_exu.sv
// Execute stage: operand select, ALU, branch/jump resolution and a one-entry
// output buffer between IDU and LSU/WBU.

// Integer ALU; funct follows RV32I funct3, funcs selects SUB/SRA.
module ysyx_23060203_ALU #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct,
    input  logic            funcs,
    output logic [XLEN-1:0] result
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    // Result mux over the eight funct3 operations
    always_comb begin
        result = '0;
        case (funct)
            3'b000:  result = funcs ? (a - b) : (a + b);
            3'b001:  result = a << shamt;
            3'b010:  result = XLEN'($signed(a) < $signed(b));
            3'b011:  result = XLEN'(a < b);
            3'b100:  result = a ^ b;
            3'b101:  result = funcs ? XLEN'($unsigned($signed(a) >>> shamt)) : (a >> shamt);
            3'b110:  result = a | b;
            default: result = a & b;
        endcase
    end
endmodule

module ysyx_23060203_exu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_src_a,
    input  logic            in_src_b,
    input  logic [2:0]      in_funct,
    input  logic            in_funcs,
    input  logic            in_br,
    input  logic [2:0]      in_br_cond,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic [4:0]      in_rd,
    input  logic [7:0]      in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_val,
    output logic [XLEN-1:0] out_dnpc,
    output logic [4:0]      out_rd,
    output logic [7:0]      out_tag,
    output logic            out_redirect
);
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] link;
    logic [XLEN:0]   diff_u;
    logic [XLEN:0]   diff_s;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic            taken;
    logic [XLEN-1:0] dnpc_d;
    logic [XLEN-1:0] val_d;
    logic            redirect_d;
    logic            accept;

    // Buffer is free when empty or draining this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand selection
    assign alu_a = in_src_a ? in_pc  : in_rs1;
    assign alu_b = in_src_b ? in_imm : in_rs2;
    assign link  = in_pc + XLEN'(PC_STEP);

    ysyx_23060203_ALU #(
        .XLEN (XLEN)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .funct  (in_funct),
        .funcs  (in_funcs),
        .result (alu_res)
    );

    // Dedicated branch comparator, independent of the ALU operand muxes
    always_comb begin
        diff_u  = {1'b0, in_rs1} - {1'b0, in_rs2};
        diff_s  = {in_rs1[XLEN-1], in_rs1} - {in_rs2[XLEN-1], in_rs2};
        cmp_eq  = (in_rs1 == in_rs2);
        cmp_lt  = diff_s[XLEN];
        cmp_ltu = diff_u[XLEN];
        taken   = 1'b0;
        case (in_br_cond)
            3'b000:  taken = cmp_eq;
            3'b001:  taken = !cmp_eq;
            3'b100:  taken = cmp_lt;
            3'b101:  taken = !cmp_lt;
            3'b110:  taken = cmp_ltu;
            3'b111:  taken = !cmp_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next-PC and result selection; jal takes precedence over br
    always_comb begin
        dnpc_d = link;
        val_d  = alu_res;
        if (in_jal) begin
            dnpc_d = alu_res & ~{{(XLEN-1){1'b0}}, in_jalr};
            val_d  = link;
        end else if (in_br && taken) begin
            dnpc_d = alu_res;
        end
        redirect_d = (dnpc_d != link);
    end

    // Output buffer valid bit; flush wins over accept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Output buffer payload, loaded only on an unflushed accept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_pc       <= '0;
            out_val      <= '0;
            out_dnpc     <= '0;
            out_rd       <= '0;
            out_tag      <= '0;
            out_redirect <= 1'b0;
        end else if (accept && !flush) begin
            out_pc       <= in_pc;
            out_val      <= val_d;
            out_dnpc     <= dnpc_d;
            out_rd       <= in_rd;
            out_tag      <= in_tag;
            out_redirect <= redirect_d;
        end
    end
endmodule
